// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and the IF/ID pipeline register.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Stall/flush pipeline register; flush inserts a bubble, stall holds, otherwise loads.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  fetch_stage_pkg::if_id_t d,
  output fetch_stage_pkg::if_id_t q
);
  import fetch_stage_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= make_bubble(NOP_INSTR);
    end else if (flush) begin
      q <= make_bubble(NOP_INSTR);
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding request FSM, one-entry skid buffer, IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        fetch_empty
);
  import fetch_stage_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc_f;
  logic [31:0]  addr_q;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic         skid_valid;
  logic         resp;
  if_id_t       if_id_d;
  if_id_t       if_id_q;

  assign imem_req  = (state == S_REQ) && !stallF && !skid_valid && !flushD;
  assign imem_addr = pc_f;
  assign resp      = (state == S_WAIT) && imem_rvalid;

  // A held (skid) response is older than anything live, so it drains first.
  always_comb begin
    if_id_d = make_bubble(NOP_INSTR);
    if (skid_valid) begin
      if_id_d.instr    = skid_instr;
      if_id_d.pc       = skid_pc;
      if_id_d.pc_plus4 = skid_pc + 32'd4;
      if_id_d.valid    = 1'b1;
    end else if (resp) begin
      if_id_d.instr    = imem_rdata;
      if_id_d.pc       = addr_q;
      if_id_d.pc_plus4 = addr_q + 32'd4;
      if_id_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc_f       <= RESET_PC;
      addr_q     <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flushD) begin
      pc_f       <= {pc_target[31:2], 2'b00};
      skid_valid <= 1'b0;
      // An in-flight response must still be swallowed once it arrives.
      case (state)
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      if (skid_valid && !stallD) begin
        skid_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            addr_q <= pc_f;
            pc_f   <= pc_f + 32'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_REQ;
            if (stallD) begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= addr_q;
            end
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst_n(rst_n),
    .stall(stallD),
    .flush(flushD),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  assign instrD      = if_id_q.instr;
  assign pcD         = if_id_q.pc;
  assign pc_plus4D   = if_id_q.pc_plus4;
  assign validD      = if_id_q.valid;
  assign fetch_empty = !if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, flushD;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD, fetch_empty;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .pc_target  (pc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .pc_plus4D  (pc_plus4D),
    .validD     (validD),
    .fetch_empty(fetch_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr    = instr;
    e.pc       = pc;
    e.pc_plus4 = pc + 32'd4;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instrD, e.instr);
      chk({tag, "_pc"}, pcD, e.pc);
      chk({tag, "_pc4"}, pc_plus4D, e.pc_plus4);
      chk({tag, "_valid"}, {31'd0, validD}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    pc_target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, validD}, 32'd0);
    chk("rst_instr", instrD, NOP);
    chk("rst_pcD", pcD, 32'd0);
    chk("rst_pc4", pc_plus4D, 32'd0);
    chk("rst_empty", {31'd0, fetch_empty}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);

    // First fetch straight after reset release
    rst_n = 1'b1; imem_gnt = 1'b1; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    push_exp(32'h0050_0093, 32'h0);
    #1;
    chk("wait_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b0; #1;
    pop_chk("basic");
    chk("basic_addr", imem_addr, 32'd4);
    chk("basic_req", {31'd0, imem_req}, 32'd1);

    // Decode stall across the response: skid captures it
    stallD = 1'b1; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0013;
    tick();
    imem_rvalid = 1'b0; #1;
    chk("skid_hold_instr", instrD, 32'h0050_0093);
    chk("skid_hold_pc", pcD, 32'd0);
    chk("skid_noreq", {31'd0, imem_req}, 32'd0);
    stallD = 1'b0;
    push_exp(32'hAAAA_0013, 32'h4);
    tick();
    pop_chk("skid");
    chk("skid_resume_req", {31'd0, imem_req}, 32'd1);
    chk("skid_resume_addr", imem_addr, 32'd8);

    // Fetch stall holds the PC
    stallF = 1'b1; imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stallF_noreq", {31'd0, imem_req}, 32'd0);
      chk("stallF_addr", imem_addr, 32'd8);
      tick();
    end
    stallF = 1'b0; #1;
    chk("stallF_rel_req", {31'd0, imem_req}, 32'd1);
    chk("stallF_rel_addr", imem_addr, 32'd8);

    // Flush while waiting: outstanding response must be dropped
    tick();
    imem_gnt = 1'b0; flushD = 1'b1; pc_target = 32'h0000_0103;
    #1;
    chk("flushW_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    flushD = 1'b0; #1;
    chk("flushW_valid", {31'd0, validD}, 32'd0);
    chk("flushW_instr", instrD, NOP);
    chk("drop_noreq", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; #1;
    chk("drop_valid", {31'd0, validD}, 32'd0);
    chk("drop_instr", instrD, NOP);
    chk("drop_addr", imem_addr, 32'h100);
    chk("drop_req", {31'd0, imem_req}, 32'd1);

    // Load a real instruction, then flush and stall together
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    push_exp(32'h1111_1111, 32'h100);
    tick();
    imem_rvalid = 1'b0; #1;
    pop_chk("pre_flush");
    stallD = 1'b1; flushD = 1'b1; pc_target = 32'hFFFF_FFFC; #1;
    chk("fs_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    stallD = 1'b0; flushD = 1'b0; #1;
    chk("fs_valid", {31'd0, validD}, 32'd0);
    chk("fs_instr", instrD, NOP);
    chk("fs_addr", imem_addr, 32'hFFFF_FFFC);

    // PC wrap-around at the top of the address space
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    push_exp(32'h2222_2222, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b0; #1;
    pop_chk("wrap");
    chk("wrap_addr", imem_addr, 32'd0);

    // Flush coincident with the response: discard it, return to REQ
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    flushD = 1'b1; pc_target = 32'h0000_0200;
    tick();
    imem_rvalid = 1'b0; flushD = 1'b0; #1;
    chk("flushR_valid", {31'd0, validD}, 32'd0);
    chk("flushR_req", {31'd0, imem_req}, 32'd1);
    chk("flushR_addr", imem_addr, 32'h200);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
